// File: rtl/eth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : eth_pkg
//  Description : Shared definitions for the RMII receive path: FSM state
//                encoding, RMII line symbols, CRC-32 constants and the
//                default video frame size.
//  Revision    : 1.0  initial release
// ============================================================================
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        HEADER   = 3'd2,
        PAYLOAD  = 3'd3,
        DROP     = 3'd4,
        FINISH   = 3'd5
    } fsm_state_t;

    localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
    localparam logic [1:0]  SFD_DIBIT      = 2'b11;

    // The CRC register is kept in non-reflected bit order (shift-left LFSR
    // fed LSB first), so the good-frame residue appears as C704DD7B.
    localparam logic [31:0] CRC_POLY       = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE    = 32'hC704_DD7B;

    localparam int          FRAME_PIXELS   = 320 * 240;

endpackage : eth_pkg
`default_nettype wire

// File: rtl/eth_unpacker_if.sv
`default_nettype none
// ============================================================================
//  Module      : eth_unpacker_if
//  Description : RMII receive inputs plus the unpacked byte-stream outputs.
//                slave  : the unpacker (consumes RMII, drives stream)
//                master : the environment (drives RMII, observes stream)
//  Ports       : crsdv, rxd            - RMII carrier/data-valid and dibit
//                axiov, axiod          - payload byte strobe and data
//                pixel_addr            - frame-buffer address of axiod
//                frame_done            - last pixel of a frame
//                packet_done, crc_ok   - end-of-packet and FCS result
//                err_count             - saturating bad/dropped packet count
//  Revision    : 1.0  initial release
// ============================================================================
interface eth_unpacker_if #(
    parameter int ADDR_W = 17
);
    logic              crsdv;
    logic [1:0]        rxd;
    logic              axiov;
    logic [7:0]        axiod;
    logic [ADDR_W-1:0] pixel_addr;
    logic              frame_done;
    logic              packet_done;
    logic              crc_ok;
    logic [7:0]        err_count;

    modport slave (
        input  crsdv, rxd,
        output axiov, axiod, pixel_addr, frame_done, packet_done, crc_ok, err_count
    );

    modport master (
        output crsdv, rxd,
        input  axiov, axiod, pixel_addr, frame_done, packet_done, crc_ok, err_count
    );
endinterface : eth_unpacker_if
`default_nettype wire

// File: rtl/crc32_byte.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_byte
//  Description : Byte-wide Ethernet CRC-32 (poly 04C11DB7, reflected input,
//                init all-ones, no output inversion). Data bits enter LSB
//                first into a shift-left register.
//  Ports       : clk   - clock
//                rst   - asynchronous active-low reset
//                clear - reload CRC_INIT (wins over valid)
//                valid - absorb data this cycle
//                data  - input byte
//                crc   - current CRC register
//  Revision    : 1.0  initial release
// ============================================================================
module crc32_byte (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        clear,
    input  wire logic        valid,
    input  wire logic [7:0]  data,
    output logic      [31:0] crc
);
    import eth_pkg::*;

    logic [31:0] r_crc;
    logic [31:0] w_crc_nxt;

    always_comb begin
        w_crc_nxt = r_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_crc_nxt[31] ^ data[i]) begin
                w_crc_nxt = {w_crc_nxt[30:0], 1'b0} ^ CRC_POLY;
            end else begin
                w_crc_nxt = {w_crc_nxt[30:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crc <= CRC_INIT;
        end else if (clear) begin
            r_crc <= CRC_INIT;
        end else if (valid) begin
            r_crc <= w_crc_nxt;
        end
    end

    assign crc = r_crc;

endmodule : crc32_byte
`default_nettype wire

// File: rtl/eth_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : eth_unpacker
//  Description : RMII receiver. Finds preamble/SFD, assembles LSB-first
//                dibits into bytes, drops the MAC header, holds back the
//                4-byte FCS through a delay line, checks CRC-32 and emits
//                payload bytes with a wrapping frame-buffer address.
//  Ports       : clk  - 50 MHz RMII reference clock
//                rst  - asynchronous active-low reset
//                bus  - eth_unpacker_if.slave (RMII in, byte stream out)
//  Revision    : 1.0  initial release
// ============================================================================
module eth_unpacker #(
    parameter int HEADER_BYTES = 14,
    parameter int MIN_PREAMBLE = 28,
    parameter int FRAME_PIXELS = eth_pkg::FRAME_PIXELS,
    parameter int ADDR_W       = 17
) (
    input  wire logic      clk,
    input  wire logic      rst,
    eth_unpacker_if.slave  bus
);
    import eth_pkg::*;

    localparam int                PRE_W     = $clog2(MIN_PREAMBLE + 1);
    localparam int                CNT_W     = $clog2(HEADER_BYTES + 5);
    // Byte counter saturates here: from this count on every release is payload
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(HEADER_BYTES + 4);
    localparam logic [CNT_W-1:0]  CNT_DLY   = CNT_W'(4);
    localparam logic [PRE_W-1:0]  PRE_MIN   = PRE_W'(MIN_PREAMBLE);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);

    fsm_state_t        r_state;
    fsm_state_t        w_state_nxt;

    logic              w_crsdv;
    logic [1:0]        w_rxd;
    logic              r_crsdv_q;
    logic [PRE_W-1:0]  r_pre_cnt;
    logic [1:0]        r_dib_cnt;
    logic [5:0]        r_shift;
    logic [CNT_W-1:0]  r_byte_cnt;
    logic [7:0]        r_dly [4];
    logic [ADDR_W-1:0] r_addr;

    logic              r_axiov;
    logic [7:0]        r_axiod;
    logic [ADDR_W-1:0] r_pixel_addr;
    logic              r_frame_done;
    logic [7:0]        r_err_count;

    logic              w_eoc;
    logic              w_in_data;
    logic              w_take;
    logic              w_byte_done;
    logic [7:0]        w_byte;
    logic              w_release;
    logic              w_emit;
    logic              w_crc_good;
    logic              w_err_inc;
    logic [31:0]       w_crc;

    assign w_crsdv     = bus.crsdv;
    assign w_rxd       = bus.rxd;

    // Two consecutive low cycles end the carrier; a lone low cycle is the
    // RMII mid-frame toggle and its dibit is ignored.
    assign w_eoc       = !w_crsdv && !r_crsdv_q;
    assign w_in_data   = (r_state == HEADER) || (r_state == PAYLOAD);
    assign w_take      = w_in_data && w_crsdv;
    assign w_byte_done = w_take && (r_dib_cnt == 2'd3);
    assign w_byte      = {w_rxd, r_shift};
    // Oldest entry leaves only when a fifth byte arrives, so the trailing
    // four bytes (the FCS) never get out.
    assign w_release   = w_byte_done && (r_byte_cnt >= CNT_DLY);
    assign w_emit      = w_release && (r_byte_cnt == CNT_FULL);
    assign w_crc_good  = (w_crc == CRC_RESIDUE) && (r_dib_cnt == 2'd0)
                         && (r_byte_cnt == CNT_FULL);

    crc32_byte u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (!w_in_data),
        .valid (w_byte_done),
        .data  (w_byte),
        .crc   (w_crc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_crsdv) begin
                    w_state_nxt = (w_rxd == PREAMBLE_DIBIT) ? PREAMBLE : DROP;
                end
            end
            PREAMBLE: begin
                if (w_crsdv) begin
                    if (w_rxd == PREAMBLE_DIBIT) begin
                        w_state_nxt = PREAMBLE;
                    end else if ((w_rxd == SFD_DIBIT) && (r_pre_cnt >= PRE_MIN)) begin
                        w_state_nxt = HEADER;
                    end else begin
                        w_state_nxt = DROP;
                    end
                end else if (!r_crsdv_q) begin
                    w_state_nxt = DROP;
                end
            end
            HEADER: begin
                if (w_eoc) begin
                    w_state_nxt = FINISH;
                end else if (w_emit) begin
                    w_state_nxt = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_eoc) begin
                    w_state_nxt = FINISH;
                end
            end
            DROP: begin
                if (w_eoc) begin
                    w_state_nxt = IDLE;
                    w_err_inc   = 1'b1;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
                w_err_inc   = !w_crc_good;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_crsdv_q    <= 1'b0;
            r_pre_cnt    <= '0;
            r_dib_cnt    <= 2'd0;
            r_shift      <= '0;
            r_byte_cnt   <= '0;
            for (int i = 0; i < 4; i++) begin
                r_dly[i] <= 8'h00;
            end
            r_addr       <= '0;
            r_axiov      <= 1'b0;
            r_axiod      <= 8'h00;
            r_pixel_addr <= '0;
            r_frame_done <= 1'b0;
            r_err_count  <= 8'h00;
        end else begin
            r_crsdv_q <= w_crsdv;

            // IDLE preloads 1 so the dibit that leaves IDLE is counted
            if (r_state == IDLE) begin
                r_pre_cnt <= PRE_W'(1);
            end else if ((r_state == PREAMBLE) && w_crsdv && (w_rxd == PREAMBLE_DIBIT)
                         && (r_pre_cnt != '1)) begin
                r_pre_cnt <= r_pre_cnt + 1'b1;
            end

            // Counters hold through FINISH so the verdict can see a partial
            // byte or a short packet, then clear.
            if (!w_in_data) begin
                r_dib_cnt  <= 2'd0;
                r_shift    <= '0;
                r_byte_cnt <= '0;
            end else if (w_take) begin
                r_dib_cnt <= r_dib_cnt + 2'd1;
                case (r_dib_cnt)
                    2'd0:    r_shift[1:0] <= w_rxd;
                    2'd1:    r_shift[3:2] <= w_rxd;
                    2'd2:    r_shift[5:4] <= w_rxd;
                    default: ;
                endcase
                if (w_byte_done && (r_byte_cnt != CNT_FULL)) begin
                    r_byte_cnt <= r_byte_cnt + 1'b1;
                end
            end

            if (w_byte_done) begin
                r_dly[0] <= w_byte;
                for (int i = 1; i < 4; i++) begin
                    r_dly[i] <= r_dly[i-1];
                end
            end

            r_axiov      <= w_emit;
            r_frame_done <= w_emit && (r_addr == ADDR_LAST);
            if (w_emit) begin
                r_axiod      <= r_dly[3];
                r_pixel_addr <= r_addr;
                r_addr       <= (r_addr == ADDR_LAST) ? '0 : r_addr + 1'b1;
            end

            if (w_err_inc && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bus.axiov       = r_axiov;
    assign bus.axiod       = r_axiod;
    assign bus.pixel_addr  = r_pixel_addr;
    assign bus.frame_done  = r_frame_done;
    assign bus.packet_done = (r_state == FINISH);
    assign bus.crc_ok      = (r_state == FINISH) && w_crc_good;
    assign bus.err_count   = r_err_count;

endmodule : eth_unpacker
`default_nettype wire

// File: tb/tb_eth_unpacker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_unpacker
//  Description : Directed self-checking bench for eth_unpacker. Expected
//                payload bytes and packet verdicts are queued as packets are
//                sent and popped as the DUT reports them. The frame size is
//                shrunk to 16 pixels so address wrap happens quickly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_eth_unpacker;

    localparam int FP = 16;

    typedef struct packed {
        logic [7:0]  d;
        logic [16:0] a;
        logic        fd;
    } exp_t;

    logic        clk;
    logic        rst;
    exp_t        exp_q[$];
    logic        pkt_q[$];
    logic [7:0]  tx[$];
    int          n_checks;
    int          n_pass;
    int          tb_addr;
    int          tb_err;

    eth_unpacker_if #(.ADDR_W(17)) bus ();

    eth_unpacker #(
        .HEADER_BYTES (14),
        .MIN_PREAMBLE (28),
        .FRAME_PIXELS (FP),
        .ADDR_W       (17)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One RMII cycle: present inputs, let the edge happen, then look at outputs.
    task automatic drive(input logic dv, input logic [1:0] d);
        exp_t e;
        logic ok;
        bus.crsdv = dv;
        bus.rxd   = d;
        @(posedge clk);
        #1;
        if (bus.axiov) begin
            if (exp_q.size() == 0) begin
                chk("axiov_stray", {31'd0, bus.axiov}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("axiod", {24'd0, bus.axiod}, {24'd0, e.d});
                chk("pixel_addr", {15'd0, bus.pixel_addr}, {15'd0, e.a});
                chk("frame_done", {31'd0, bus.frame_done}, {31'd0, e.fd});
            end
        end else if (bus.frame_done) begin
            chk("frame_done_stray", {31'd0, bus.frame_done}, 32'd0);
        end
        if (bus.packet_done) begin
            if (pkt_q.size() == 0) begin
                chk("packet_done_stray", {31'd0, bus.packet_done}, 32'd0);
            end else begin
                ok = pkt_q.pop_front();
                chk("crc_ok", {31'd0, bus.crc_ok}, {31'd0, ok});
            end
        end
    endtask

    function automatic logic [31:0] eth_fcs();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (tx[i]) begin
            c = c ^ {24'd0, tx[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic build(input int nhdr, input int npay, input logic [7:0] first,
                         input bit with_fcs, input bit flip);
        logic [31:0] f;
        tx.delete();
        for (int i = 0; i < nhdr; i++) tx.push_back(8'hA0 + 8'(i));
        for (int i = 0; i < npay; i++) tx.push_back(first + 8'(i));
        if (with_fcs) begin
            f = eth_fcs();
            if (flip) f[0] = ~f[0];
            for (int i = 0; i < 4; i++) tx.push_back(f[8*i +: 8]);
        end
    endtask

    task automatic push_payload(input int n, input logic [7:0] first);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.d  = first + 8'(i);
            e.a  = 17'(tb_addr);
            e.fd = (tb_addr == FP - 1);
            exp_q.push_back(e);
            tb_addr = (tb_addr == FP - 1) ? 0 : tb_addr + 1;
        end
    endtask

    task automatic push_pkt(input logic ok);
        pkt_q.push_back(ok);
        if (!ok) tb_err++;
    endtask

    // stop_bytes < 0 sends the whole tx queue followed by end-of-carrier.
    task automatic send(input int npre, input int bad_pre_pos, input int toggle_at,
                        input int stop_bytes);
        int nb;
        logic [7:0] b;
        for (int i = 0; i < npre; i++) drive(1'b1, (i == bad_pre_pos) ? 2'b10 : 2'b01);
        drive(1'b1, 2'b11);
        nb = (stop_bytes < 0) ? tx.size() : stop_bytes;
        for (int i = 0; i < nb; i++) begin
            b = tx[i];
            for (int k = 0; k < 4; k++) begin
                if (i * 4 + k == toggle_at) drive(1'b0, 2'b00);
                drive(1'b1, b[2*k +: 2]);
            end
        end
        if (stop_bytes < 0) begin
            repeat (5) drive(1'b0, 2'b00);
        end
    endtask

    task automatic end_check();
        chk("bytes_pending", exp_q.size(), 32'd0);
        chk("pkt_pending", pkt_q.size(), 32'd0);
        chk("err_count", {24'd0, bus.err_count}, tb_err);
    endtask

    task automatic reset_outputs_check();
        chk("rst_axiov", {31'd0, bus.axiov}, 32'd0);
        chk("rst_axiod", {24'd0, bus.axiod}, 32'd0);
        chk("rst_pixel_addr", {15'd0, bus.pixel_addr}, 32'd0);
        chk("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        chk("rst_packet_done", {31'd0, bus.packet_done}, 32'd0);
        chk("rst_crc_ok", {31'd0, bus.crc_ok}, 32'd0);
        chk("rst_err_count", {24'd0, bus.err_count}, 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        tb_addr   = 0;
        tb_err    = 0;
        rst       = 1'b0;
        bus.crsdv = 1'b0;
        bus.rxd   = 2'b00;
        #35;
        reset_outputs_check();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) drive(1'b0, 2'b00);

        // good packet, payload 00..07
        build(14, 8, 8'h00, 1'b1, 1'b0);
        push_payload(8, 8'h00); push_pkt(1'b1);
        send(28, -1, -1, -1);
        end_check();

        // FCS bit flipped: bytes still delivered, verdict bad
        build(14, 8, 8'h00, 1'b1, 1'b1);
        push_payload(8, 8'h00); push_pkt(1'b0);
        send(28, -1, -1, -1);
        end_check();

        // bad preamble dibit at position 5: silently dropped
        build(14, 8, 8'h40, 1'b1, 1'b0);
        tb_err++;
        send(28, 4, -1, -1);
        end_check();

        // two 10-byte packets crossing the frame boundary
        build(14, 10, 8'h20, 1'b1, 1'b0);
        push_payload(10, 8'h20); push_pkt(1'b1);
        send(28, -1, -1, -1);
        build(14, 10, 8'h60, 1'b1, 1'b0);
        push_payload(10, 8'h60); push_pkt(1'b1);
        send(28, -1, -1, -1);
        end_check();

        // single-cycle carrier toggle mid-payload
        build(14, 8, 8'h00, 1'b1, 1'b0);
        push_payload(8, 8'h00); push_pkt(1'b1);
        send(28, -1, (14 + 3) * 4 + 2, -1);
        end_check();

        // one preamble dibit short
        build(14, 8, 8'h00, 1'b1, 1'b0);
        tb_err++;
        send(27, -1, -1, -1);
        end_check();

        // runt packet: packet_done with crc_ok=0
        build(10, 0, 8'h00, 1'b0, 1'b0);
        push_pkt(1'b0);
        send(28, -1, -1, -1);
        end_check();

        // reset in the middle of the payload, then a clean packet
        build(14, 8, 8'h80, 1'b1, 1'b0);
        push_payload(2, 8'h80);
        send(28, -1, -1, 20);
        drive(1'b1, tx[20][1:0]);
        drive(1'b1, tx[20][3:2]);
        #5;
        rst = 1'b0;
        #1;
        reset_outputs_check();
        tb_addr = 0;
        tb_err  = 0;
        drive(1'b1, 2'b01);
        drive(1'b1, 2'b01);
        rst = 1'b1;
        repeat (3) drive(1'b0, 2'b00);
        end_check();
        build(14, 8, 8'h10, 1'b1, 1'b0);
        push_payload(8, 8'h10); push_pkt(1'b1);
        send(28, -1, -1, -1);
        end_check();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_eth_unpacker
`default_nettype wire

// File: doc/eth_unpacker.md
Name: eth_unpacker

Overview:
- RMII receive-side counterpart of the FPGA1 Ethernet transmit path, for FPGA2's 50 MHz eth_refclk domain.
- Detects preamble/SFD, reassembles dibits into bytes, strips the MAC header, withholds the 4-byte FCS and checks CRC-32.
- Emits payload bytes as a byte stream with a running 320x240 frame-buffer write address for the FPGA2 frame buffer / VGA path.

Parameters:
HEADER_BYTES, 14, bytes after SFD discarded before payload (dest MAC, src MAC, ethertype)
MIN_PREAMBLE, 28, minimum count of consecutive 2'b01 dibits required before SFD
FRAME_PIXELS, 76800, payload bytes per video frame (320*240); address wraps here
ADDR_W, 17, pixel_addr width

Ports:
clk  in  1  50 MHz RMII reference clock; all logic on rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
crsdv  in  1  RMII carrier-sense/data-valid
rxd  in  2  RMII receive dibit
axiov  out  1  payload byte valid, single-cycle pulse
axiod  out  8  payload byte
pixel_addr  out  ADDR_W  frame-buffer address for axiod, valid with axiov
frame_done  out  1  pulse with the byte written at FRAME_PIXELS-1
packet_done  out  1  pulse at end of a packet that reached HEADER state
crc_ok  out  1  FCS result, valid while packet_done=1
err_count  out  8  saturating count of dropped or bad-CRC packets

Behaviour:
- Reset (rst=0, async): all outputs 0; pixel_addr=0; err_count=0; FSM=IDLE; delay line empty; CRC=32'hFFFFFFFF.
- Inputs are used directly; no internal synchronizers (same clock as PHY).
- FSM states:
  - IDLE: crsdv=1 and rxd=01 -> PREAMBLE, pre_cnt=1. Any other crsdv=1 dibit -> DROP.
  - PREAMBLE: rxd=01 -> pre_cnt++ (saturating). rxd=11 with pre_cnt>=MIN_PREAMBLE -> HEADER. Any other dibit, 11 too early, or end-of-carrier -> DROP.
  - HEADER/PAYLOAD: byte assembly, header counting and end-of-carrier handling as below.
  - DROP: ignore input until end-of-carrier, then err_count++ (saturate at 255) -> IDLE. No packet_done.
- End-of-carrier: crsdv=0 on two consecutive cycles.
  - A single-cycle crsdv=0 is a toggle; its dibit is discarded.
  - End-of-carrier from HEADER/PAYLOAD -> FINISH (one cycle) -> IDLE.
- Byte assembly: dibits are LSB first. 1st dibit -> bits[1:0], 2nd -> [3:2], 3rd -> [5:4], 4th -> [7:6]. Byte completes on the cycle the 4th dibit is sampled.
- Every completed byte is fed to the CRC-32 (poly 04C11DB7, reflected, init all-ones) and pushed into a 4-entry delay line.
- The oldest entry is released only when a 5th byte is pushed, so the final 4 bytes (FCS) are never emitted.
- Released byte index < HEADER_BYTES: discarded; FSM moves HEADER -> PAYLOAD at index HEADER_BYTES.
- Released byte index >= HEADER_BYTES: axiov=1 for one cycle, axiod=byte, pixel_addr=current address.
  - Latency: axiov asserts on the cycle after the 4th dibit of byte N+4 is sampled.
  - Address increments after each output byte.
  - At FRAME_PIXELS-1: frame_done=1 with that byte; next address is 0.
- pixel_addr persists across packets; only reset clears it.
- FINISH: packet_done=1; crc_ok=1 iff CRC register equals residue 32'hC704DD7B.
  - crc_ok=0 -> err_count++ (saturating). Bytes already written are not retracted.
- A packet shorter than HEADER_BYTES+4 bytes, or with a partial trailing byte: packet_done=1, crc_ok=0. The partial byte is dropped.
- crsdv asserted on the cycle immediately after FINISH is treated as IDLE input.
- Reset mid-packet: immediate return to reset state; the following packet must be received normally.

Decomposition:
- Shared package eth_pkg: fsm state enum (IDLE, PREAMBLE, HEADER, PAYLOAD, DROP, FINISH), PREAMBLE_DIBIT=2'b01, SFD_DIBIT=2'b11, CRC_POLY, CRC_INIT, CRC_RESIDUE, FRAME_PIXELS=320*240.
- One sub-module: crc32_byte (byte-wide, reflected CRC-32, inputs clk/rst/clear/valid/byte, output crc).
- The CRC block is shared with the FPGA1 packer checker.

Test Plan:
- Good packet: 28x01 dibits, 11, 14 header bytes, payload 0x00..0x07, correct FCS -> 8 axiov pulses, axiod 0x00..0x07, pixel_addr 0..7, packet_done with crc_ok=1, err_count=0.
- Same packet with FCS LSB flipped -> identical 8 bytes out, packet_done with crc_ok=0, err_count=1.
- Preamble dibit 10 at position 5 -> no axiov, no packet_done, err_count=1. Following good packet starts at pixel_addr 0.
- FRAME_PIXELS=16, two good packets of 10 payload bytes -> frame_done on the 16th byte (addr 15); next bytes at addr 0..3.
- Single-cycle crsdv=0 inserted mid-payload (dibit discarded, retransmitted next cycle) -> same output as the good packet, crc_ok=1.
- rst=0 pulsed mid-payload of packet 1, then a good packet -> all outputs 0 during reset; packet 2 outputs at pixel_addr 0 with crc_ok=1.
